// File: rtl/key_event_sequencer.sv
// key_event_sequencer: debounces encoded keypad vectors, turns note keys
// into note-on/off events and owns the octave/mode/goof registers.
module key_event_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OCT_MAX         = 7,
  parameter int OCT_RESET       = 4,
  parameter int NUM_MODES       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       octave_key_up,
  input  logic       octave_key_down,
  input  logic       mode_key,
  input  logic       goof_key,
  input  logic [4:0] keycode,
  input  logic       strobe,
  input  logic       event_ready,
  output logic       event_valid,
  output logic       event_note_on,
  output logic [4:0] event_keycode,
  output logic [2:0] event_octave,
  output logic [2:0] octave,
  output logic [1:0] mode,
  output logic       goof_en
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] OCT_TOP  = 3'(OCT_MAX);
  localparam logic [2:0] OCT_INIT = 3'(OCT_RESET);
  localparam logic [1:0] MODE_TOP = 2'(NUM_MODES - 1);

  typedef struct packed {
    logic       up;
    logic       down;
    logic       mode;
    logic       goof;
    logic [4:0] code;
    logic       strobe;
  } key_vec_t;

  typedef struct packed {
    logic       note_on;
    logic [4:0] code;
    logic [2:0] oct;
  } event_t;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        state_q, state_d;
  key_vec_t      vec;
  key_vec_t      cap_q, cap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    oct_q, oct_d;
  logic [2:0]    oheld_q, oheld_d;
  logic [1:0]    mode_q, mode_d;
  logic          goof_q, goof_d;
  logic          ev_valid_q, ev_valid_d;
  event_t        ev_q, ev_d;
  event_t        issue_ev;
  logic          issue;
  logic          ev_free;
  logic          vec_match;
  logic          cap_fn;
  logic [2:0]    fn_oct;
  logic [1:0]    fn_mode;
  logic          fn_goof;

  assign vec = {octave_key_up, octave_key_down,
                mode_key, goof_key, keycode, strobe};

  assign vec_match = (vec == cap_q);
  assign cap_fn    = cap_q.up | cap_q.down |
                     cap_q.mode | cap_q.goof;
  assign ev_free   = ~ev_valid_q | event_ready;

  // Register effect of the captured function key.
  always_comb begin
    fn_oct  = oct_q;
    fn_mode = mode_q;
    fn_goof = goof_q;
    priority case (1'b1)
      cap_q.up: begin
        if (oct_q < OCT_TOP)
          fn_oct = oct_q + 3'd1;
      end
      cap_q.down: begin
        if (oct_q != 3'd0)
          fn_oct = oct_q - 3'd1;
      end
      cap_q.mode: begin
        fn_mode = (mode_q == MODE_TOP) ?
                  2'd0 : mode_q + 2'd1;
      end
      cap_q.goof: fn_goof = ~goof_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    oct_d    = oct_q;
    oheld_d  = oheld_q;
    mode_d   = mode_q;
    goof_d   = goof_q;
    issue    = 1'b0;
    issue_ev = '{note_on: 1'b0,
                 code:    cap_q.code,
                 oct:     oct_q};
    unique case (state_q)
      IDLE: begin
        if (vec.strobe) begin
          cap_d   = vec;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!vec_match) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (cap_fn) begin
          oct_d   = fn_oct;
          mode_d  = fn_mode;
          goof_d  = fn_goof;
          state_d = HELD;
        end else if (ev_free) begin
          issue            = 1'b1;
          issue_ev.note_on = 1'b1;
          oheld_d          = oct_q;
          state_d          = HELD;
        end
      end
      HELD: begin
        // A pending note-off that cannot be posted holds everything.
        if (!vec_match && (cap_fn || ev_free)) begin
          if (!cap_fn) begin
            issue        = 1'b1;
            issue_ev.oct = oheld_q;
          end
          cnt_d = '0;
          if (vec.strobe) begin
            cap_d   = vec;
            state_d = DEBOUNCE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_valid_d = ev_valid_q & ~event_ready;
    ev_d       = ev_q;
    if (issue) begin
      ev_valid_d = 1'b1;
      ev_d       = issue_ev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      cnt_q   <= '0;
      oheld_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      oheld_q <= oheld_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oct_q  <= OCT_INIT;
      mode_q <= '0;
      goof_q <= 1'b0;
    end else begin
      oct_q  <= oct_d;
      mode_q <= mode_d;
      goof_q <= goof_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid_q <= 1'b0;
      ev_q       <= '0;
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_q       <= ev_d;
    end
  end

  assign event_valid   = ev_valid_q;
  assign event_note_on = ev_q.note_on;
  assign event_keycode = ev_q.code;
  assign event_octave  = ev_q.oct;
  assign octave        = oct_q;
  assign mode          = mode_q;
  assign goof_en       = goof_q;

endmodule

// File: tb/tb_key_event_sequencer.sv
// tb_key_event_sequencer: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_key_event_sequencer;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       octave_key_up;
  logic       octave_key_down;
  logic       mode_key;
  logic       goof_key;
  logic [4:0] keycode;
  logic       strobe;
  logic       event_ready;
  logic       event_valid;
  logic       event_note_on;
  logic [4:0] event_keycode;
  logic [2:0] event_octave;
  logic [2:0] octave;
  logic [1:0] mode;
  logic       goof_en;

  key_event_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .OCT_MAX(7),
    .OCT_RESET(4),
    .NUM_MODES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .octave_key_up(octave_key_up),
    .octave_key_down(octave_key_down),
    .mode_key(mode_key),
    .goof_key(goof_key),
    .keycode(keycode),
    .strobe(strobe),
    .event_ready(event_ready),
    .event_valid(event_valid),
    .event_note_on(event_note_on),
    .event_keycode(event_keycode),
    .event_octave(event_octave),
    .octave(octave),
    .mode(mode),
    .goof_en(goof_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] IDLE_V = 10'b0;
  localparam logic [9:0] UP_V   = 10'b1000_00000_1;
  localparam logic [9:0] DN_V   = 10'b0100_00000_1;
  localparam logic [9:0] MD_V   = 10'b0010_00000_1;
  localparam logic [9:0] GF_V   = 10'b0001_00000_1;

  typedef struct {
    logic [9:0] v;
    logic       rdy;
    int         cyc;
    logic       ev;
    logic       on;
    logic [4:0] code;
    logic [2:0] eoct;
    logic [2:0] oct;
    logic [1:0] md;
    logic       gf;
  } row_t;

  row_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // behavioural model state
  logic       m_valid, m_on;
  logic [4:0] m_code;
  logic [2:0] m_eoct;
  int         m_oct, m_mode;
  logic       m_goof;
  bit         trk, own;
  logic [9:0] cand;
  int         run, own_oct;

  function automatic logic [9:0] note(int c);
    return {4'b0, 5'(c), 1'b1};
  endfunction

  function automatic void add(logic [9:0] v, logic rdy,
      int cyc, logic ev, logic on, int code, int eoct,
      int oct, int md, logic gf);
    row_t r;
    r.v = v; r.rdy = rdy; r.cyc = cyc;
    r.ev = ev; r.on = on; r.code = 5'(code);
    r.eoct = 3'(eoct); r.oct = 3'(oct);
    r.md = 2'(md); r.gf = gf;
    tbl.push_back(r);
  endfunction

  task automatic drive(logic [9:0] v);
    {octave_key_up, octave_key_down, mode_key, goof_key,
     keycode, strobe} = v;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic ev, logic on,
      logic [4:0] code, logic [2:0] eoct, logic [2:0] oct,
      logic [1:0] md, logic gf);
    chk({nm, ".valid"}, event_valid, ev);
    if (ev) begin
      chk({nm, ".note_on"}, event_note_on, on);
      chk({nm, ".keycode"}, event_keycode, code);
      chk({nm, ".ev_oct"}, event_octave, eoct);
    end
    chk({nm, ".octave"}, octave, oct);
    chk({nm, ".mode"}, mode, md);
    chk({nm, ".goof"}, goof_en, gf);
  endtask

  task automatic chk_reset(string nm);
    chk({nm, ".valid"}, event_valid, 0);
    chk({nm, ".note_on"}, event_note_on, 0);
    chk({nm, ".keycode"}, event_keycode, 0);
    chk({nm, ".ev_oct"}, event_octave, 0);
    chk({nm, ".octave"}, octave, 4);
    chk({nm, ".mode"}, mode, 0);
    chk({nm, ".goof"}, goof_en, 0);
  endtask

  task automatic do_reset();
    drive(IDLE_V);
    event_ready = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_on = 0; m_code = 0; m_eoct = 0;
    m_oct = 4; m_mode = 0; m_goof = 0;
    trk = 0; own = 0; cand = 0; run = 0; own_oct = 0;
  endtask

  task automatic emit(logic on, logic [4:0] c, int o);
    m_valid = 1; m_on = on; m_code = c; m_eoct = 3'(o);
  endtask

  // One clock edge of the reference behaviour, from the rules.
  task automatic model_step(logic [9:0] v, logic rdy);
    bit free, is_fn;
    free  = !m_valid || rdy;
    is_fn = |cand[9:6];
    if (m_valid && rdy) m_valid = 0;
    if (own) begin
      if (v != cand && (is_fn || free)) begin
        if (!is_fn) emit(0, cand[5:1], own_oct);
        own = 0;
        if (v[0]) begin trk = 1; cand = v; run = 1; end
      end
    end else if (trk) begin
      if (v != cand) trk = 0;
      else if (run < D) run++;
      else if (is_fn) begin
        if (cand[9]) m_oct = (m_oct < 7) ? m_oct + 1 : 7;
        else if (cand[8]) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
        else if (cand[7]) m_mode = (m_mode + 1) % 4;
        else m_goof = !m_goof;
        trk = 0; own = 1;
      end else if (free) begin
        emit(1, cand[5:1], m_oct);
        own_oct = m_oct;
        trk = 0; own = 1;
      end
    end else if (v[0]) begin
      trk = 1; cand = v; run = 1;
    end
  endtask

  function automatic logic [9:0] rand_vec();
    int r;
    int codes[4] = '{0, 3, 9, 31};
    r = $urandom_range(0, 9);
    if (r < 3)
      return (r == 0) ? {4'b0, 5'($urandom), 1'b0} : IDLE_V;
    if (r < 7)
      return note(codes[$urandom_range(0, 3)]);
    return {4'b1000 >> $urandom_range(0, 3), 5'd0, 1'b1};
  endfunction

  initial begin
    int exp_oct, exp_md;
    logic exp_gf;
    logic [9:0] cur;
    int hold;

    // table: note hold, short pulses, function keys
    add(note(9), 1, 3, 0, 0, 0, 0, 4, 0, 0);
    add(note(9), 1, 1, 0, 0, 0, 0, 4, 0, 0);
    add(note(9), 1, 1, 1, 1, 9, 4, 4, 0, 0);
    add(note(9), 1, 5, 0, 0, 0, 0, 4, 0, 0);
    add(IDLE_V,  1, 1, 1, 0, 9, 4, 4, 0, 0);
    add(IDLE_V,  1, 3, 0, 0, 0, 0, 4, 0, 0);
    for (int l = 1; l <= 3; l++) begin
      add(note(7), 1, l, 0, 0, 0, 0, 4, 0, 0);
      add(IDLE_V,  1, 2, 0, 0, 0, 0, 4, 0, 0);
    end
    add(UP_V,    1, 3, 0, 0, 0, 0, 4, 0, 0);
    add(IDLE_V,  1, 2, 0, 0, 0, 0, 4, 0, 0);
    add(note(7), 1, D + 1, 1, 1, 7, 4, 4, 0, 0);
    add(IDLE_V,  1, 1, 1, 0, 7, 4, 4, 0, 0);
    add(IDLE_V,  1, 2, 0, 0, 0, 0, 4, 0, 0);
    exp_oct = 4; exp_md = 0; exp_gf = 0;
    for (int i = 0; i < 5; i++) begin
      exp_oct = (exp_oct == 7) ? 7 : exp_oct + 1;
      add(UP_V, 1, D + 1, 0, 0, 0, 0, exp_oct, 0, 0);
      add(IDLE_V, 1, 1, 0, 0, 0, 0, exp_oct, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      exp_oct = (exp_oct == 0) ? 0 : exp_oct - 1;
      add(DN_V, 1, D + 1, 0, 0, 0, 0, exp_oct, 0, 0);
      add(IDLE_V, 1, 1, 0, 0, 0, 0, exp_oct, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      exp_md = (exp_md + 1) % 4;
      add(MD_V, 1, D + 1, 0, 0, 0, 0, 0, exp_md, 0);
      add(IDLE_V, 1, 1, 0, 0, 0, 0, 0, exp_md, 0);
    end
    for (int i = 0; i < 2; i++) begin
      exp_gf = !exp_gf;
      add(GF_V, 1, D + 1, 0, 0, 0, 0, 0, exp_md, exp_gf);
      add(IDLE_V, 1, 1, 0, 0, 0, 0, 0, exp_md, exp_gf);
    end
    add(GF_V, 1, 12, 0, 0, 0, 0, 0, exp_md, 1);
    add(IDLE_V, 1, 2, 0, 0, 0, 0, 0, exp_md, 1);

    rst = 1'b0;
    #1;
    do_reset();
    chk_reset("reset");
    foreach (tbl[i]) begin
      drive(tbl[i].v);
      event_ready = tbl[i].rdy;
      tick(tbl[i].cyc);
      chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].on,
              tbl[i].code, tbl[i].eoct, tbl[i].oct,
              tbl[i].md, tbl[i].gf);
    end

    // note, octave up through release, note, direct change
    do_reset();
    drive(note(3)); tick(D + 1);
    chk_out("a.on3", 1, 1, 3, 4, 4, 0, 0);
    drive(UP_V); tick(1);
    chk_out("a.off3", 1, 0, 3, 4, 4, 0, 0);
    tick(D - 1);
    chk_out("a.upwait", 0, 0, 0, 0, 4, 0, 0);
    tick(1);
    chk_out("a.up", 0, 0, 0, 0, 5, 0, 0);
    drive(note(5)); tick(D + 1);
    chk_out("a.on5", 1, 1, 5, 5, 5, 0, 0);
    drive(note(3)); tick(1);
    chk_out("a.off5", 1, 0, 5, 5, 5, 0, 0);
    tick(D - 1);
    chk_out("a.gap", 0, 0, 0, 0, 5, 0, 0);
    tick(1);
    chk_out("a.on3b", 1, 1, 3, 5, 5, 0, 0);
    drive(IDLE_V); tick(1);
    chk_out("a.off3b", 1, 0, 3, 5, 5, 0, 0);
    tick(1);
    chk_out("a.quiet", 0, 0, 0, 0, 5, 0, 0);

    // consumer stall across press and release
    do_reset();
    event_ready = 1'b0;
    drive(note(9)); tick(D + 1);
    chk_out("b.on", 1, 1, 9, 4, 4, 0, 0);
    drive(IDLE_V); tick(1);
    chk_out("b.stall1", 1, 1, 9, 4, 4, 0, 0);
    tick(14);
    chk_out("b.stall15", 1, 1, 9, 4, 4, 0, 0);
    event_ready = 1'b1; tick(1);
    chk_out("b.off", 1, 0, 9, 4, 4, 0, 0);
    tick(1);
    chk_out("b.done", 0, 0, 0, 0, 4, 0, 0);

    // async reset during debounce and with an event pending
    do_reset();
    drive(UP_V); tick(D + 1);
    drive(IDLE_V); tick(1);
    chk_out("c.up", 0, 0, 0, 0, 5, 0, 0);
    drive(note(9)); tick(2);
    #3 rst = 1'b1;
    #1 chk_reset("c.rst_deb");
    @(posedge clk); #1;
    rst = 1'b0;
    tick(D - 1);
    chk_out("c.after1", 0, 0, 0, 0, 4, 0, 0);
    drive(IDLE_V); tick(5);
    chk_out("c.after2", 0, 0, 0, 0, 4, 0, 0);
    drive(note(9)); tick(D + 1);
    chk_out("c.on", 1, 1, 9, 4, 4, 0, 0);
    #3 rst = 1'b1;
    #1 chk_reset("c.rst_ev");
    @(posedge clk); #1;
    drive(IDLE_V);
    rst = 1'b0;
    tick(6);
    chk_out("c.noev", 0, 0, 0, 0, 4, 0, 0);

    // randomized traffic against the model
    do_reset();
    model_reset();
    hold = 0;
    cur = IDLE_V;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        cur = rand_vec();
        hold = $urandom_range(1, 8);
        drive(cur);
      end
      hold--;
      event_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      model_step(cur, event_ready);
      #1;
      chk_out("rand", m_valid, m_on, m_code, m_eoct,
              3'(m_oct), 2'(m_mode), m_goof);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
